// File: rtl/fifo_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_word_packer
// Description : Pops bytes from a synchronous byte FIFO and packs BYTES
//               consecutive bytes, little-endian, into one BYTES*8-bit word
//               presented on a valid/ready output. A flush request emits a
//               partially filled word together with its byte count.
//
// Ports
//   clk         in   single clock, rising edge
//   rst_n       in   synchronous active-low reset
//   fifo_empty  in   FIFO empty flag
//   fifo_data   in   FIFO read data, valid the cycle after fifo_r_en
//   fifo_r_en   out  FIFO pop request (combinational)
//   flush       in   request to emit the partial word (pulse or level)
//   m_valid     out  output word valid
//   m_ready     in   downstream accept
//   m_data      out  packed word, byte k in [8k+7:8k]
//   m_bytes     out  number of valid bytes in m_data (1..BYTES)
//
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_word_packer #(
    parameter int BYTES = 4,
    parameter int CW    = $clog2(BYTES + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fifo_empty,
    input  logic [7:0]         fifo_data,
    output logic               fifo_r_en,
    input  logic               flush,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [BYTES*8-1:0] m_data,
    output logic [CW-1:0]      m_bytes
);

    localparam logic [CW-1:0] c_bytes     = CW'(BYTES);
    localparam logic [CW:0]   c_bytes_ext = (CW + 1)'(BYTES);

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_OUT  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_count;
    logic [CW-1:0]      w_count_nxt;
    logic               r_pend;
    logic               r_flush_req;
    logic               w_flush_req_nxt;
    logic [BYTES*8-1:0] r_data;
    logic [BYTES*8-1:0] w_data_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic [CW-1:0]      r_bytes;
    logic [CW-1:0]      w_bytes_nxt;
    logic [CW:0]        w_inflight;
    logic               w_r_en;

    // Bytes already held plus the one still in flight; one bit wider so the
    // sum never wraps when count is already at BYTES.
    assign w_inflight = {1'b0, r_count} + {{CW{1'b0}}, r_pend};

    // Pop only while filling, with no flush pending, and only if the word
    // still has room once the in-flight byte lands (never over-pop).
    assign w_r_en = rst_n & ~fifo_empty & (r_state == S_FILL) & ~r_flush_req
                  & (w_inflight < c_bytes_ext);

    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_data_nxt      = r_data;
        w_valid_nxt     = r_valid;
        w_bytes_nxt     = r_bytes;
        w_flush_req_nxt = r_flush_req | flush;

        unique case (r_state)
            S_FILL: begin
                if (r_pend) begin
                    // The byte popped last cycle lands in lane 'count'.
                    for (int k = 0; k < BYTES; k++) begin
                        if (r_count == CW'(k)) begin
                            w_data_nxt[8*k +: 8] = fifo_data;
                        end
                    end
                    w_count_nxt = r_count + CW'(1);
                    if (w_count_nxt == c_bytes) begin
                        w_state_nxt = S_OUT;
                        w_valid_nxt = 1'b1;
                        w_bytes_nxt = c_bytes;
                    end
                end else if (r_flush_req && (r_count != '0)) begin
                    w_state_nxt = S_OUT;
                    w_valid_nxt = 1'b1;
                    w_bytes_nxt = r_count;
                end

                // Nothing buffered and nothing in flight: the flush has
                // nothing left to emit, so drop it unless it is re-asserted.
                if (!r_pend && (r_count == '0) && !flush) begin
                    w_flush_req_nxt = 1'b0;
                end
            end

            S_OUT: begin
                if (m_ready) begin
                    w_state_nxt = S_FILL;
                    w_count_nxt = '0;
                    w_data_nxt  = '0;
                    w_valid_nxt = 1'b0;
                    w_bytes_nxt = '0;
                end
            end

            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_FILL;
            r_count     <= '0;
            r_pend      <= 1'b0;
            r_flush_req <= 1'b0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_bytes     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_pend      <= w_r_en;
            r_flush_req <= w_flush_req_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_bytes     <= w_bytes_nxt;
        end
    end

    assign fifo_r_en = w_r_en;
    assign m_valid   = r_valid;
    assign m_data    = r_data;
    assign m_bytes   = r_bytes;

endmodule
`default_nettype wire

// File: tb/tb_fifo_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_word_packer
// Description : Self-checking bench for fifo_word_packer. A queue-based FIFO
//               model feeds the packer; expected words are formed from the
//               written byte stream by chunking into BYTES-sized groups, with
//               flushes closing partial groups.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_word_packer;

    localparam int BYTES = 4;
    localparam int CW    = $clog2(BYTES + 1);
    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               fifo_empty;
    logic [7:0]         fifo_data;
    logic               fifo_r_en;
    logic               flush;
    logic               m_valid;
    logic               m_ready;
    logic [BYTES*8-1:0] m_data;
    logic [CW-1:0]      m_bytes;

    always #5 clk = ~clk;

    fifo_word_packer #(.BYTES(BYTES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_r_en  (fifo_r_en),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_bytes    (m_bytes)
    );

    typedef struct {
        logic [63:0] data;
        int          nb;
    } word_t;

    logic [7:0] q[$];          // FIFO contents
    logic [7:0] wq[$];         // bytes waiting to be written into the FIFO
    logic [7:0] pending[$];    // written bytes not yet assigned to a word
    word_t      exp_words[$];

    int checks = 0;
    int fails  = 0;
    int pop_cnt = 0;
    int words_acc = 0;
    int cyc = 0;
    int first_ren = -1;
    int mv_cyc = -1;
    bit full_seen = 1'b0;
    bit rand_ready = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic void close_word();
        word_t w;
        w.data = '0;
        w.nb   = pending.size();
        for (int i = 0; i < pending.size(); i++) begin
            w.data = w.data | (64'(pending[i]) << (8 * i));
        end
        exp_words.push_back(w);
        pending.delete();
    endfunction

    task automatic write_byte(input logic [7:0] b);
        wq.push_back(b);
        pending.push_back(b);
        if (pending.size() == BYTES) close_word();
    endtask

    task automatic flush_expect();
        if (pending.size() != 0) close_word();
    endtask

    // One clock period: observe pre-edge outputs, advance the edge, then
    // update the FIFO model as a real FIFO would at that edge.
    task automatic tick();
        logic  ren;
        bit    full_pre;
        word_t w;
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
        #1;
        ren = fifo_r_en;
        if (ren && first_ren < 0) first_ren = cyc;
        if (m_valid && mv_cyc < 0) mv_cyc = cyc;
        if (m_valid && m_ready && rst_n) begin
            words_acc++;
            chk("word_expected", 64'(exp_words.size() != 0), 64'd1);
            if (exp_words.size() != 0) begin
                w = exp_words.pop_front();
                chk("m_data", 64'(m_data), w.data);
                chk("m_bytes", 64'(m_bytes), 64'(w.nb));
            end
        end
        if (ren) pop_cnt++;
        full_pre = (q.size() == DEPTH);
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_n) begin
            q.delete();
            wq.delete();
            pending.delete();
            exp_words.delete();
            fifo_data = 8'h00;
        end else begin
            if (ren) begin
                chk("pop_nonempty", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) fifo_data = q.pop_front();
            end
            if (!full_pre && wq.size() != 0) q.push_back(wq.pop_front());
        end
        fifo_empty = (q.size() == 0);
        if (q.size() == DEPTH) full_seen = 1'b1;
        #1;
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while (n < maxc && !(exp_words.size() == 0 && wq.size() == 0 &&
                             q.size() == 0 && !m_valid)) begin
            tick();
            n++;
        end
        chk("drain_done", 64'(n < maxc), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_pops;
        int base_words;
        int n;
        int bad_ren;
        int changes;
        bit have_held;
        logic [BYTES*8-1:0] held;

        rst_n      = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = 8'h00;
        flush      = 1'b0;
        m_ready    = 1'b1;

        // Reset state
        repeat (3) tick();
        chk("reset_m_valid", 64'(m_valid), 64'd0);
        chk("reset_m_data", 64'(m_data), 64'd0);
        chk("reset_m_bytes", 64'(m_bytes), 64'd0);
        fifo_empty = 1'b0;
        #1;
        chk("reset_r_en_gated", 64'(fifo_r_en), 64'd0);
        fifo_empty = 1'b1;
        rst_n = 1'b1;
        tick();

        // Full word and latency
        first_ren  = -1;
        mv_cyc     = -1;
        base_words = words_acc;
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        write_byte(8'h44);
        chk("model_word0", exp_words[0].data, 64'h44332211);
        drain(50);
        chk("full_latency", 64'(mv_cyc - first_ren), 64'(BYTES + 1));
        chk("full_words", 64'(words_acc - base_words), 64'd1);

        // Streaming 12 random bytes
        base_pops  = pop_cnt;
        base_words = words_acc;
        for (int i = 0; i < 12; i++) write_byte(8'($urandom));
        drain(100);
        chk("stream_pops", 64'(pop_cnt - base_pops), 64'd12);
        chk("stream_words", 64'(words_acc - base_words), 64'd3);

        // Streaming with random downstream ready
        base_words = words_acc;
        rand_ready = 1'b1;
        for (int i = 0; i < 16; i++) write_byte(8'($urandom));
        drain(400);
        rand_ready = 1'b0;
        m_ready    = 1'b1;
        chk("rand_ready_words", 64'(words_acc - base_words), 64'd4);

        // Flush partial, then flush with an empty buffer
        base_words = words_acc;
        write_byte(8'hAA);
        write_byte(8'hBB);
        drain(50);
        repeat (4) tick();
        chk("no_word_before_flush", 64'(m_valid), 64'd0);
        flush = 1'b1;
        flush_expect();
        chk("model_partial", exp_words[0].data, 64'h0000BBAA);
        tick();
        flush = 1'b0;
        drain(50);
        chk("flush_words", 64'(words_acc - base_words), 64'd1);
        base_words = words_acc;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (10) tick();
        chk("empty_flush_no_word", 64'(words_acc - base_words), 64'd0);

        // Back-pressure
        m_ready    = 1'b0;
        full_seen  = 1'b0;
        base_words = words_acc;
        bad_ren    = 0;
        changes    = 0;
        have_held  = 1'b0;
        held       = '0;
        for (int i = 0; i < 10; i++) write_byte(8'($urandom));
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m_valid) begin
                if (fifo_r_en) bad_ren++;
                if (have_held && m_data !== held) changes++;
                held      = m_data;
                have_held = 1'b1;
            end
        end
        chk("stall_valid", 64'(m_valid), 64'd1);
        chk("stall_data", 64'(m_data), exp_words[0].data);
        chk("stall_r_en_low", 64'(bad_ren), 64'd0);
        chk("stall_data_stable", 64'(changes), 64'd0);
        chk("stall_full_seen", 64'(full_seen), 64'd1);
        m_ready = 1'b1;
        drain(100);
        repeat (4) tick();
        flush = 1'b1;
        flush_expect();
        tick();
        flush = 1'b0;
        drain(50);
        chk("stall_words", 64'(words_acc - base_words), 64'd3);

        // Reset mid-operation with count=2 and a byte in flight
        base_pops = pop_cnt;
        for (int i = 0; i < 4; i++) write_byte(8'($urandom));
        n = 0;
        while (pop_cnt < base_pops + 3 && n < 50) begin
            tick();
            n++;
        end
        chk("pre_reset_r_en", 64'(fifo_r_en), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_m_valid", 64'(m_valid), 64'd0);
        chk("midrst_m_data", 64'(m_data), 64'd0);
        chk("midrst_m_bytes", 64'(m_bytes), 64'd0);
        chk("midrst_r_en", 64'(fifo_r_en), 64'd0);
        base_words = words_acc;
        write_byte(8'hC1);
        write_byte(8'hC2);
        write_byte(8'hC3);
        write_byte(8'hC4);
        drain(50);
        chk("post_reset_words", 64'(words_acc - base_words), 64'd1);

        // Flush coinciding with the final capture
        base_pops  = pop_cnt;
        base_words = words_acc;
        for (int i = 0; i < 4; i++) write_byte(8'($urandom));
        n = 0;
        while (pop_cnt < base_pops + 4 && n < 50) begin
            tick();
            n++;
        end
        chk("coinc_pre_valid", 64'(m_valid), 64'd0);
        flush = 1'b1;
        flush_expect();
        tick();
        flush = 1'b0;
        chk("coinc_valid", 64'(m_valid), 64'd1);
        chk("coinc_bytes", 64'(m_bytes), 64'(BYTES));
        drain(50);
        repeat (6) tick();
        chk("coinc_words", 64'(words_acc - base_words), 64'd1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_word_packer.md
# fifo_word_packer

Downstream consumer of `synchronous_fifo`: pops bytes from the FIFO read port and packs `BYTES` consecutive bytes, little-endian, into one `BYTES*8`-bit word, presented on a valid/ready output. A `flush` request emits a partially filled word with a byte count. This lets the byte FIFO drain into word-wide logic without a width mismatch.

## Interface
- `BYTES`, 4: bytes per output word; legal values 2..8.
- `CW`, `$clog2(BYTES+1)`: width of the byte-count output. Derived; do not override.
- `clk`  in  1  single clock; everything is updated on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_data`  in  8  FIFO `data_out`. Valid in the cycle after `fifo_r_en` was sampled high.
- `fifo_r_en`  out  1  pop request to the FIFO `r_en`. Combinational.
- `flush`  in  1  request to emit a partial word. Single-cycle pulse or level.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  `BYTES*8`  packed word; byte k occupies `[8k+7:8k]`.
- `m_bytes`  out  `CW`  number of valid bytes in `m_data`, range 1..`BYTES`.

## Operation
- **State.**
  - `state`: FILL or OUT.
  - `count`: bytes held, 0..`BYTES`.
  - `pend`: 1-bit flag, high when a pop was issued last cycle.
  - `flush_req`: latched flush.
- **Pop issue.**
  - `fifo_r_en = rst_n & !fifo_empty & (state==FILL) & !flush_req & (count + pend < BYTES)`.
  - Each cycle, `pend` is loaded with the value `fifo_r_en` had in that cycle.
  - Back-to-back pops are allowed, so one byte per cycle is sustained.
- **Capture.**
  - When `pend` is high, `fifo_data` is written into byte lane `count` and `count` increments.
  - Byte lanes not yet written hold 0.
- **FILL → OUT**, on either of:
  - the capture that makes `count == BYTES`; or
  - `flush_req` high with `pend==0` and `count>0`.
  - On entry: `m_valid=1`, `m_bytes=count`.
- **OUT.**
  - `m_data`, `m_bytes` and `m_valid` stay stable until `m_ready`.
  - No pops are issued in OUT.
  - On `m_valid & m_ready`: `count=0`, all byte lanes cleared, `m_valid=0`, next state FILL.
- **Flush.**
  - `flush` high in any cycle sets `flush_req`. It can be set in either state.
  - While `flush_req` is set, no new pops are issued; a pop already in flight (`pend`) is still captured.
  - `flush_req` clears in FILL when `pend==0` and `count==0`. This covers the case where a flush arrives with nothing buffered: no word is emitted.
  - A flush raised during OUT survives the handshake. It clears on the next cycle because `count` is 0 by then, so it does not produce a second word.
- **Reset** (`rst_n` low at a clock edge), from any state:
  - state FILL; `count=0`, `pend=0`, `flush_req=0`.
  - `m_valid=0`, `m_data=0`, `m_bytes=0`.
  - `fifo_r_en` is forced 0 while `rst_n` is low.
  - A byte in flight is discarded. The FIFO shares `rst_n`, so it is reset too.

## Timing
- Cycle n is the period after clock edge n.
- Pop/capture pipeline: `fifo_r_en` high in cycle n → FIFO updates `data_out` at edge n+1 → packer captures at edge n+2.
- With `fifo_empty` low throughout, a full word takes this sequence:
  - `fifo_r_en` high in cycles 0..`BYTES-1`;
  - `m_valid` rises in cycle `BYTES+1` (cycle 5 for `BYTES=4`).
- `fifo_r_en` drops in the cycle where `count + pend == BYTES`. It never over-pops.
- After a handshake at edge k, the state is FILL in cycle k and pops may resume in that cycle. Minimum period per word is `BYTES+2` cycles.
- Output stall (`m_ready=0`): `fifo_r_en` stays 0, so the FIFO fills and the upstream `full` back-pressures the writer.
- `fifo_empty` going high mid-word: the packer waits in FILL with a partial `count`, holding its contents, for as long as needed.
- `flush` and the final capture in the same cycle: the full word is emitted with `m_bytes=BYTES`. The flush then clears as a no-op.

## Test plan
- **Full word.** Reset, write 0x11,0x22,0x33,0x44 into the FIFO, hold `m_ready=1` → one word `m_data=0x44332211`, `m_bytes=4`; `m_valid` high exactly 5 cycles after the first `fifo_r_en`.
- **Streaming, no duplicates.** Write 12 random bytes, `m_ready=1` → three words in FIFO order; `fifo_r_en` asserted exactly 12 times; no byte duplicated or dropped.
- **Flush partial.** Write 0xAA,0xBB, pulse `flush` after both are captured → `m_data=0x0000BBAA`, `m_bytes=2`. A later `flush` with an empty buffer → no `m_valid`.
- **Back-pressure.** Hold `m_ready=0` for 20 cycles while writing 10 bytes → first word held stable; `fifo_r_en` low throughout the stall. Then release → remaining bytes packed in order; FIFO `full` seen during the stall if depth ≤ 6.
- **Reset mid-operation.** Assert `rst_n=0` for one edge while `pend=1` and `count=2` → next cycle `m_valid=0`, `m_data=0`, `m_bytes=0`, `fifo_r_en=0`; the next four bytes written form a clean new word.
- **Flush and final capture together.** Assert `flush` in the same cycle as the fourth capture → single word with `m_bytes=4`; no extra empty word emitted.
